// File: rtl/inst_ram2.sv
// Instruction memory: 1-cycle fetch with stall hold, RUN/LOAD mode FSM gating byte-enabled program writes.
// Optional per-byte even parity storage and checking when INST_RAM_PARITY_EN is defined.
module inst_ram2 #(
  parameter int unsigned    W   = 32,
  parameter int unsigned    H   = 8,
  parameter logic [W-1:0]   NOP = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     pc,
  input  logic             re,
  input  logic             stall,
  output logic [W-1:0]     inst_data,
  output logic             inst_valid,
  output logic             addr_fault,
  output logic             par_err,
  input  logic             load_start,
  input  logic             load_done,
  output logic             busy,
  input  logic             is_write,
  input  logic [W-1:0]     im_addr,
  input  logic [W-1:0]     im_inst,
  input  logic [W/8-1:0]   im_be,
  output logic             wr_fault
);

  localparam int unsigned NB    = W / 8;
  localparam int unsigned DEPTH = 1 << H;

  typedef enum logic {RUN, LOAD} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           afault_q, afault_d;
  logic           perr_q, perr_d;
  logic           busy_q;
  logic           wrf_q, wrf_d;

  logic [W-1:0]   mem [DEPTH];

  function automatic logic addr_bad(input logic [W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (H + 2)) != '0);
  endfunction

  logic [H-1:0]   f_idx, w_idx;
  logic           f_bad, w_bad, wr_en;
  logic [W-1:0]   rd_word;
  logic           rd_mism;

  assign f_idx   = pc[H+1:2];
  assign w_idx   = im_addr[H+1:2];
  assign f_bad   = addr_bad(pc);
  assign w_bad   = addr_bad(im_addr);
  assign wr_en   = is_write && (state_q == LOAD) && !w_bad;
  assign rd_word = mem[f_idx];

`ifdef INST_RAM_PARITY_EN
  logic [NB-1:0]  par_mem [DEPTH];
  logic [NB-1:0]  rd_par;

  assign rd_par = par_mem[f_idx];

  always_comb begin
    rd_mism = 1'b0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (rd_par[b] != (^rd_word[8*b +: 8])) rd_mism = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (im_be[b]) par_mem[w_idx][b] <= ^im_inst[8*b +: 8];
      end
    end
  end
`else
  assign rd_mism = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (im_be[b]) mem[w_idx][8*b +: 8] <= im_inst[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    afault_d = afault_q;
    perr_d   = perr_q;
    wrf_d    = is_write && ((state_q == RUN) || w_bad);

    case (state_q)
      RUN:  if (load_start) state_d = LOAD;
      LOAD: if (load_done)  state_d = RUN;
      default: state_d = RUN;
    endcase

    // Mode override beats stall so a fetch in flight at load entry is discarded.
    if ((state_q == LOAD) || load_start) begin
      data_d   = '0;
      valid_d  = 1'b0;
      afault_d = 1'b0;
      perr_d   = 1'b0;
    end else if (!stall) begin
      if (re) begin
        valid_d  = 1'b1;
        afault_d = f_bad;
        data_d   = f_bad ? NOP : rd_word;
        perr_d   = !f_bad && rd_mism;
      end else begin
        data_d   = '0;
        valid_d  = 1'b0;
        afault_d = 1'b0;
        perr_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      data_q   <= '0;
      valid_q  <= 1'b0;
      afault_q <= 1'b0;
      perr_q   <= 1'b0;
      busy_q   <= 1'b0;
      wrf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      afault_q <= afault_d;
      perr_q   <= perr_d;
      busy_q   <= (state_d == LOAD);
      wrf_q    <= wrf_d;
    end
  end

  assign inst_data  = data_q;
  assign inst_valid = valid_q;
  assign addr_fault = afault_q;
  assign par_err    = perr_q;
  assign busy       = busy_q;
  assign wr_fault   = wrf_q;

endmodule

// File: tb/tb_inst_ram2.sv
// Directed plus randomized checks of inst_ram2 against a word-array reference model.
module tb_inst_ram2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        re = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] inst_data;
  logic        inst_valid;
  logic        addr_fault;
  logic        par_err;
  logic        load_start = 1'b0;
  logic        load_done = 1'b0;
  logic        busy;
  logic        is_write = 1'b0;
  logic [31:0] im_addr = '0;
  logic [31:0] im_inst = '0;
  logic [3:0]  im_be = '0;
  logic        wr_fault;

  inst_ram2 #(.W(32), .H(8), .NOP(32'h00000013)) dut (
    .clk(clk), .rst(rst), .pc(pc), .re(re), .stall(stall),
    .inst_data(inst_data), .inst_valid(inst_valid), .addr_fault(addr_fault),
    .par_err(par_err), .load_start(load_start), .load_done(load_done),
    .busy(busy), .is_write(is_write), .im_addr(im_addr), .im_inst(im_inst),
    .im_be(im_be), .wr_fault(wr_fault)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] mem_m [256];
  bit          in_load = 0;
  int          par_bad = -1;
  logic [31:0] e_data = '0;
  logic        e_valid = 0, e_fault = 0, e_par = 0, e_busy = 0, e_wrf = 0;

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd1024);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data"},  inst_data,  e_data);
    chk({tag, ".valid"}, 32'(inst_valid), 32'(e_valid));
    chk({tag, ".fault"}, 32'(addr_fault), 32'(e_fault));
    chk({tag, ".par"},   32'(par_err),    32'(e_par));
    chk({tag, ".busy"},  32'(busy),       32'(e_busy));
    chk({tag, ".wrf"},   32'(wr_fault),   32'(e_wrf));
  endtask

  // Advance one clock: predict from current inputs, then compare after the edge.
  task automatic tick(input string tag);
    logic [31:0] mask;
    int idx;
    e_wrf = is_write && (!in_load || is_bad(im_addr));
    if (in_load && is_write && !is_bad(im_addr)) begin
      idx = int'(im_addr / 4);
      for (int b = 0; b < 4; b++) begin
        if (im_be[b]) begin
          mask = 32'hFF << (8 * b);
          mem_m[idx] = (mem_m[idx] & ~mask) | (im_inst & mask);
        end
      end
    end
    if (in_load || load_start) begin
      e_valid = 0; e_data = 0; e_fault = 0; e_par = 0;
    end else if (!stall) begin
      if (!re) begin
        e_valid = 0; e_data = 0; e_fault = 0; e_par = 0;
      end else if (is_bad(pc)) begin
        e_valid = 1; e_data = 32'h00000013; e_fault = 1; e_par = 0;
      end else begin
        e_valid = 1; e_data = mem_m[pc / 4]; e_fault = 0;
        e_par = (int'(pc / 4) == par_bad);
      end
    end
    if (!in_load && load_start) in_load = 1;
    else if (in_load && load_done) in_load = 0;
    e_busy = in_load;
    @(posedge clk); #1;
    chk_all(tag);
  endtask

  task automatic idle();
    re = 0; stall = 0; is_write = 0; load_start = 0; load_done = 0; im_be = '0;
  endtask

  initial begin
    logic [31:0] r;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 0;

    // Load program: full word then byte-0 overwrite
    load_start = 1; tick("ld_enter"); load_start = 0;
    is_write = 1; im_addr = 32'h10; im_inst = 32'hDEADBEEF; im_be = 4'b1111; tick("wr_full");
    im_inst = 32'h000000AA; im_be = 4'b0001; tick("wr_byte");
    is_write = 0; load_done = 1; tick("ld_exit"); load_done = 0;
    re = 1; pc = 32'h10; tick("fetch10");
    chk("fetch10.const", inst_data, 32'hDEADBEAA);

    // Address faults
    pc = 32'h12; tick("misalign");
    chk("misalign.nop", inst_data, 32'h00000013);
    pc = 32'h400; tick("oor");
    pc = 32'h8000_0010; tick("oor_hi");

    // Stall hold
    pc = 32'h10; tick("pre_stall");
    stall = 1; pc = 32'h0; re = 1;
    for (int i = 0; i < 3; i++) tick("stall");
    chk("stall.const", inst_data, 32'hDEADBEAA);
    stall = 0; re = 0; tick("re0");

    // Dropped writes
    is_write = 1; im_addr = 32'h10; im_inst = 32'h12345678; im_be = 4'hF; tick("wr_run");
    is_write = 0; load_start = 1; tick("wrf_clr"); load_start = 0;
    is_write = 1; im_addr = 32'h400; tick("wr_oor");
    is_write = 0; load_done = 1; tick("ld_exit2"); load_done = 0;
    re = 1; pc = 32'h10; tick("unchanged");
    chk("unchanged.const", inst_data, 32'hDEADBEAA);

    // Load entry discards in-flight fetch even under stall
    stall = 1; load_start = 1; tick("ld_over_stall"); load_start = 0; stall = 0;
    for (int i = 0; i < 32; i++) begin
      is_write = 1; im_addr = 32'(i * 4); im_inst = $urandom; im_be = 4'hF;
      if (i == 4) im_inst = 32'hDEADBEAA;
      tick("init");
    end
    idle(); load_done = 1; tick("ld_exit3"); idle();

    // Randomized mixed traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      load_start = ($urandom_range(0, 19) == 0);
      load_done  = ($urandom_range(0, 4) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      re         = ($urandom_range(0, 3) != 0);
      is_write   = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: pc = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
        1: pc = 32'h400 + 32'($urandom_range(0, 255) * 4);
        default: pc = 32'($urandom_range(0, 31) * 4);
      endcase
      im_addr = ($urandom_range(0, 7) == 0) ? (r | 32'h1) : 32'($urandom_range(0, 31) * 4);
      im_inst = $urandom;
      im_be   = 4'($urandom_range(0, 15));
      tick("rand");
    end

    // Return to RUN, then async reset in the middle of a fetch
    idle(); load_done = 1; tick("to_run"); idle();
    re = 1; pc = 32'h10; tick("pre_rst");
    #2 rst = 1;
    #1;
    e_data = 0; e_valid = 0; e_fault = 0; e_par = 0; e_busy = 0; e_wrf = 0; in_load = 0;
    chk_all("async_rst");
    @(negedge clk); rst = 0;
    tick("post_rst");
    chk("post_rst.valid", 32'(inst_valid), 32'd1);

`ifdef INST_RAM_PARITY_EN
    dut.par_mem[4][0] = ~dut.par_mem[4][0];
    par_bad = 4;
    re = 1; pc = 32'h10; tick("parity");
    chk("parity.const", 32'(par_err), 32'd1);
`else
    re = 1; pc = 32'h10; tick("nopar");
`endif
    idle(); tick("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
